// File: rtl/gen_write_logic_capture_pkg.sv
// -----------------------------------------------------------------------------
// capture_pkg
//   Shared definitions for the packet-capture write path. It holds the default
//   geometry of the capture memories, the capture FSM state encoding and a
//   small helper that classifies states as busy.
// -----------------------------------------------------------------------------
package capture_pkg;

   // Default geometry of the capture memories
   localparam int unsigned NUM_MEM    = 24;                // capture memories
   localparam int unsigned PATH_W     = 9;                 // bits per ADC path
   localparam int unsigned ADDR_W     = 15;                // depth = 2**ADDR_W
   localparam int unsigned DLY_W      = 16;                // trigger delay width
   localparam int unsigned WORD_W     = 4 * PATH_W;        // 4 paths per word
   localparam int unsigned LAST_ADDR  = (1 << ADDR_W) - 1; // final write address
   localparam int unsigned MEM_48PATH = 12;                // memories used in 48-path mode

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } cap_state_t;

   // A run is in progress from arming until the buffer fills or is aborted
   function automatic logic is_busy(input cap_state_t s);
      return (s == ST_ARM) || (s == ST_DELAY) || (s == ST_CAPTURE);
   endfunction

endpackage

// File: rtl/gen_write_logic_capture_word_pack.sv
// -----------------------------------------------------------------------------
// cap_word_pack
//   Combinational mapping of the flat ADC path bus into one memory word per
//   capture memory. Word i carries paths 4i..4i+3 with path 4i in the least
//   significant slot.
//
// Ports
//   adc_din : NUM_MEM*4 paths, path p at bits [p*PATH_W +: PATH_W]
//   words   : NUM_MEM words, word i at bits [i*4*PATH_W +: 4*PATH_W]
// -----------------------------------------------------------------------------
module cap_word_pack #(
   parameter int unsigned NUM_MEM = capture_pkg::NUM_MEM,
   parameter int unsigned PATH_W  = capture_pkg::PATH_W
) (
   input  logic [NUM_MEM*4*PATH_W-1:0] adc_din,
   output logic [NUM_MEM*4*PATH_W-1:0] words
);

   localparam int unsigned WW = 4 * PATH_W;

   always_comb begin
      words = '0;
      for (int unsigned i = 0; i < NUM_MEM; i++) begin
         for (int unsigned j = 0; j < 4; j++) begin
            words[i*WW + j*PATH_W +: PATH_W] = adc_din[(4*i + j)*PATH_W +: PATH_W];
         end
      end
   end

endmodule

// File: rtl/gen_write_logic_capture.sv
// -----------------------------------------------------------------------------
// gen_write_logic_capture
//   Capture-side writer for the packet-capture memories. On each valid ADC
//   beat during a capture run it writes one packed word to every enabled
//   memory at a shared, incrementing address until the buffer is full. A run
//   is started from the register file, optionally waits for a rising edge on
//   ext_trig, then skips rf_trig_delay valid beats before capturing. The block
//   owns the memory ports only while mdio_read_en is low.
//
// Ports
//   clk, rst            : capture clock, synchronous active-high reset
//   rf_96path_en        : 1 = all memories written, 0 = lower half only
//   rf_cap_start_pulse  : one-cycle start request
//   rf_cap_abort_pulse  : one-cycle abort request (wins over start)
//   rf_trig_mode        : 0 = immediate, 1 = wait for ext_trig rising edge
//   rf_trig_delay       : valid beats skipped after the trigger
//   ext_trig            : external trigger level
//   mdio_read_en        : MDIO read path owns the memories
//   adc_vld, adc_din    : ADC beat strobe and flat path bus
//   mem_chip_en         : per-memory chip enable (registered)
//   mem_wr_en           : shared write strobe (registered)
//   mem_addr, mem_wdata : shared address and packed words (hold between writes)
//   cap_busy            : run in progress (ARM, DELAY, CAPTURE)
//   cap_done            : buffer filled
//   cap_wr_cnt          : words written in the current run
// -----------------------------------------------------------------------------
module gen_write_logic_capture #(
   parameter int unsigned NUM_MEM = capture_pkg::NUM_MEM,
   parameter int unsigned PATH_W  = capture_pkg::PATH_W,
   parameter int unsigned ADDR_W  = capture_pkg::ADDR_W,
   parameter int unsigned DLY_W   = capture_pkg::DLY_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rf_96path_en,
   input  logic                          rf_cap_start_pulse,
   input  logic                          rf_cap_abort_pulse,
   input  logic                          rf_trig_mode,
   input  logic [DLY_W-1:0]              rf_trig_delay,
   input  logic                          ext_trig,
   input  logic                          mdio_read_en,
   input  logic                          adc_vld,
   input  logic [NUM_MEM*4*PATH_W-1:0]   adc_din,
   output logic [NUM_MEM-1:0]            mem_chip_en,
   output logic                          mem_wr_en,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [NUM_MEM*4*PATH_W-1:0]   mem_wdata,
   output logic                          cap_busy,
   output logic                          cap_done,
   output logic [ADDR_W:0]               cap_wr_cnt
);

   import capture_pkg::*;

   localparam int unsigned WW = 4 * PATH_W;

   cap_state_t              state_q, state_d;
   logic                    trig_q;
   logic                    mode96_q;
   logic [DLY_W-1:0]        dly_cnt_q;
   logic [ADDR_W:0]         wr_cnt_q;
   logic [NUM_MEM*WW-1:0]   pack_words;
   logic [NUM_MEM-1:0]      chip_mask;

   logic busy;
   logic abort;
   logic start_ok;
   logic trig_edge;
   logic arm_entry;
   logic dly_step;
   logic wr_fire;
   logic last_wr;

   cap_word_pack #(
      .NUM_MEM (NUM_MEM),
      .PATH_W  (PATH_W)
   ) u_pack (
      .adc_din (adc_din),
      .words   (pack_words)
   );

   // Control qualifiers shared by the FSM and the datapath
   always_comb begin
      busy      = is_busy(state_q);
      // MDIO taking the memories during a run can only be a rising level,
      // because a start is refused while mdio_read_en is high.
      abort     = busy && (rf_cap_abort_pulse || mdio_read_en);
      start_ok  = rf_cap_start_pulse && !rf_cap_abort_pulse && !mdio_read_en;
      trig_edge = ext_trig && !trig_q;
      dly_step  = (state_q == ST_DELAY) && adc_vld && (dly_cnt_q != rf_trig_delay);
      wr_fire   = (state_q == ST_CAPTURE) && adc_vld && !abort;
      last_wr   = wr_fire && (wr_cnt_q[ADDR_W-1:0] == '1);
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      arm_entry = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d   = ST_ARM;
               arm_entry = 1'b1;
            end
         end
         ST_ARM: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!rf_trig_mode || trig_edge) begin
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            // Leave as soon as the last skipped beat is counted so the very
            // next beat is captured; a zero delay leaves without counting.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (dly_cnt_q == rf_trig_delay) begin
               state_d = ST_CAPTURE;
            end else if (dly_step && (DLY_W'(dly_cnt_q + 1'b1) == rf_trig_delay)) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (last_wr) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Memories above the 48-path half stay disabled when the run is 48-path
   always_comb begin
      chip_mask = '1;
      if (!mode96_q) begin
         for (int unsigned i = MEM_48PATH; i < NUM_MEM; i++) begin
            chip_mask[i] = 1'b0;
         end
      end
   end

   // State, run bookkeeping and registered memory port
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         trig_q      <= 1'b0;
         mode96_q    <= 1'b0;
         dly_cnt_q   <= '0;
         wr_cnt_q    <= '0;
         cap_done    <= 1'b0;
         mem_chip_en <= '0;
         mem_wr_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         state_q     <= state_d;
         trig_q      <= ext_trig;
         mem_wr_en   <= wr_fire;
         mem_chip_en <= wr_fire ? chip_mask : '0;

         if (arm_entry) begin
            mode96_q  <= rf_96path_en;
            dly_cnt_q <= '0;
            wr_cnt_q  <= '0;
            cap_done  <= 1'b0;
         end else begin
            if (dly_step && !abort) begin
               dly_cnt_q <= dly_cnt_q + 1'b1;
            end
            if (wr_fire) begin
               wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (last_wr) begin
               cap_done <= 1'b1;
            end
         end

         if (wr_fire) begin
            mem_addr  <= wr_cnt_q[ADDR_W-1:0];
            mem_wdata <= pack_words;
         end
      end
   end

   assign cap_busy   = busy;
   assign cap_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_gen_write_logic_capture.sv
module tb_gen_write_logic_capture;

   localparam int NM    = 24;
   localparam int PW    = 9;
   localparam int AW    = 15;
   localparam int DW    = 16;
   localparam int WDW   = NM * 4 * PW;
   localparam int LAST  = 32767;
   localparam int NEVER = 1 << 30;

   logic            clk = 1'b0;
   logic            rst;
   logic            rf_96path_en;
   logic            rf_cap_start_pulse;
   logic            rf_cap_abort_pulse;
   logic            rf_trig_mode;
   logic [DW-1:0]   rf_trig_delay;
   logic            ext_trig;
   logic            mdio_read_en;
   logic            adc_vld;
   logic [WDW-1:0]  adc_din;
   logic [NM-1:0]   mem_chip_en;
   logic            mem_wr_en;
   logic [AW-1:0]   mem_addr;
   logic [WDW-1:0]  mem_wdata;
   logic            cap_busy;
   logic            cap_done;
   logic [AW:0]     cap_wr_cnt;

   gen_write_logic_capture dut (
      .clk                (clk),
      .rst                (rst),
      .rf_96path_en       (rf_96path_en),
      .rf_cap_start_pulse (rf_cap_start_pulse),
      .rf_cap_abort_pulse (rf_cap_abort_pulse),
      .rf_trig_mode       (rf_trig_mode),
      .rf_trig_delay      (rf_trig_delay),
      .ext_trig           (ext_trig),
      .mdio_read_en       (mdio_read_en),
      .adc_vld            (adc_vld),
      .adc_din            (adc_din),
      .mem_chip_en        (mem_chip_en),
      .mem_wr_en          (mem_wr_en),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .cap_busy           (cap_busy),
      .cap_done           (cap_done),
      .cap_wr_cnt         (cap_wr_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              cyc;
      logic [AW-1:0]   addr;
      logic [NM-1:0]   ce;
      logic [WDW-1:0]  wdata;
      logic            done;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   bit   mon_en = 1'b0;

   // Path p value: either its own index, or the current cycle on every path
   function automatic logic [PW-1:0] path_val(input bit cst, input int c, input int p);
      return cst ? PW'(p) : PW'(c);
   endfunction

   function automatic logic [WDW-1:0] mk_din(input bit cst, input int c);
      logic [WDW-1:0] d;
      for (int p = 0; p < NM * 4; p++) d[p*PW +: PW] = path_val(cst, c, p);
      return d;
   endfunction

   // Expected memory words: word i = {path 4i+3, 4i+2, 4i+1, 4i}
   function automatic logic [WDW-1:0] mk_words(input bit cst, input int c);
      logic [WDW-1:0] w;
      for (int i = 0; i < NM; i++)
         w[i*36 +: 36] = {path_val(cst, c, 4*i+3), path_val(cst, c, 4*i+2),
                          path_val(cst, c, 4*i+1), path_val(cst, c, 4*i)};
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive n beats; beats driven at or after cap_start with adc_vld=1 are
   // expected to be written one cycle later at the next address.
   task automatic run_beats(input int n, input int cap_start, input bit cst, input bit toggle,
                            input logic [NM-1:0] ce, input int k_in, output int k_out);
      int k;
      int c;
      logic v;
      exp_t e;
      k = k_in;
      for (int i = 0; i < n; i++) begin
         c       = cyc;
         v       = toggle ? ((c % 2) == 1) : 1'b1;
         adc_vld = v;
         adc_din = mk_din(cst, c);
         if (v && c >= cap_start && k <= LAST) begin
            e.cyc   = c + 1;
            e.addr  = AW'(k);
            e.ce    = ce;
            e.wdata = mk_words(cst, c);
            e.done  = (k == LAST);
            q.push_back(e);
            k++;
         end
         tick();
      end
      adc_vld = 1'b0;
      k_out   = k;
   endtask

   task automatic start_run(output int s);
      rf_cap_start_pulse = 1'b1;
      tick();
      rf_cap_start_pulse = 1'b0;
      s = cyc;
   endtask

   task automatic abort_now();
      rf_cap_abort_pulse = 1'b1;
      adc_vld            = 1'b1;
      tick();
      rf_cap_abort_pulse = 1'b0;
      adc_vld            = 1'b0;
   endtask

   // Scoreboard monitor
   exp_t e_m;
   bit   bad;
   always @(negedge clk) begin
      if (mon_en) begin
         n_vec++;
         if (mem_wr_en === 1'b1) begin
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL spurious_write: addr %0d at cycle %0d, no write expected", mem_addr, cyc);
            end else begin
               e_m = q.pop_front();
               bad = 1'b0;
               if (cyc != e_m.cyc) begin
                  bad = 1'b1;
                  $display("FAIL wr_cycle: got %0d expected %0d (addr %0d)", cyc, e_m.cyc, e_m.addr);
               end
               if (mem_addr !== e_m.addr) begin
                  bad = 1'b1;
                  $display("FAIL wr_addr: got %0d expected %0d", mem_addr, e_m.addr);
               end
               if (mem_chip_en !== e_m.ce) begin
                  bad = 1'b1;
                  $display("FAIL wr_chip_en: got %h expected %h (addr %0d)", mem_chip_en, e_m.ce, e_m.addr);
               end
               if (cap_done !== e_m.done) begin
                  bad = 1'b1;
                  $display("FAIL wr_done: got %b expected %b (addr %0d)", cap_done, e_m.done, e_m.addr);
               end
               if (mem_wdata !== e_m.wdata) begin
                  bad = 1'b1;
                  for (int i = 0; i < NM; i++) begin
                     if (mem_wdata[i*36 +: 36] !== e_m.wdata[i*36 +: 36]) begin
                        $display("FAIL wr_wdata word %0d: got %h expected %h (addr %0d)",
                                 i, mem_wdata[i*36 +: 36], e_m.wdata[i*36 +: 36], e_m.addr);
                        break;
                     end
                  end
               end
               if (bad) n_err++;
            end
         end else if (mem_chip_en !== '0 || mem_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL idle_strobe: wr_en %b chip_en %h at cycle %0d", mem_wr_en, mem_chip_en, cyc);
         end
      end
   end

   initial begin
      int s, k, t;
      rst                = 1'b1;
      rf_96path_en       = 1'b1;
      rf_cap_start_pulse = 1'b0;
      rf_cap_abort_pulse = 1'b0;
      rf_trig_mode       = 1'b0;
      rf_trig_delay      = '0;
      ext_trig           = 1'b0;
      mdio_read_en       = 1'b0;
      adc_vld            = 1'b0;
      adc_din            = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_chip_en", 64'(mem_chip_en), 0);
      chk("rst_wr_en",   64'(mem_wr_en), 0);
      chk("rst_addr",    64'(mem_addr), 0);
      chk("rst_wdata",   64'(|mem_wdata), 0);
      chk("rst_busy",    64'(cap_busy), 0);
      chk("rst_done",    64'(cap_done), 0);
      chk("rst_wr_cnt",  64'(cap_wr_cnt), 0);
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();

      // Start refused while MDIO owns the memories
      mdio_read_en = 1'b1;
      start_run(s);
      mdio_read_en = 1'b0;
      chk("mdio_start_ignored", 64'(cap_busy), 0);

      // External trigger with delay 5; ext_trig high before arming gives no edge
      rf_trig_mode  = 1'b1;
      rf_trig_delay = 16'd5;
      ext_trig      = 1'b1;
      tick();
      start_run(s);
      while (cyc < 99) run_beats(1, NEVER, 1'b0, 1'b0, '1, 0, k);
      chk("arm_hold_busy",   64'(cap_busy), 1);
      chk("arm_hold_wr_cnt", 64'(cap_wr_cnt), 0);
      ext_trig = 1'b0;
      run_beats(1, NEVER, 1'b0, 1'b0, '1, 0, k);
      t        = cyc;
      ext_trig = 1'b1;
      run_beats(30, t + 6, 1'b0, 1'b0, '1, 0, k);
      abort_now();
      chk("trig_abort_busy",   64'(cap_busy), 0);
      chk("trig_abort_wr_cnt", 64'(cap_wr_cnt), 64'(k));
      chk("trig_writes",       64'(k), 24);
      ext_trig      = 1'b0;
      rf_trig_mode  = 1'b0;
      rf_trig_delay = '0;

      // Full 96-path run, path p carries value p
      start_run(s);
      chk("full96_busy",   64'(cap_busy), 1);
      chk("full96_cnt0",   64'(cap_wr_cnt), 0);
      run_beats(4, s + 2, 1'b1, 1'b0, 24'hFFFFFF, 0, k);
      chk("full96_word1",  64'(mem_wdata[36 +: 36]), 64'({9'd7, 9'd6, 9'd5, 9'd4}));
      run_beats(LAST + 4, s + 2, 1'b1, 1'b0, 24'hFFFFFF, k, k);
      chk("full96_done",   64'(cap_done), 1);
      chk("full96_idle",   64'(cap_busy), 0);
      chk("full96_wr_cnt", 64'(cap_wr_cnt), 32768);

      // Full 48-path run from DONE; mode change after arming must not matter
      rf_96path_en = 1'b0;
      start_run(s);
      rf_96path_en = 1'b1;
      chk("full48_done_cleared", 64'(cap_done), 0);
      run_beats(LAST + 8, s + 2, 1'b1, 1'b0, 24'h000FFF, 0, k);
      chk("full48_done",   64'(cap_done), 1);
      chk("full48_wr_cnt", 64'(cap_wr_cnt), 32768);

      // adc_vld toggling: address advances on valid beats only
      start_run(s);
      run_beats(40, s + 2, 1'b0, 1'b1, 24'hFFFFFF, 0, k);
      abort_now();
      chk("toggle_wr_cnt", 64'(cap_wr_cnt), 64'(k));
      chk("toggle_writes", 64'(k), 19);

      // Abort after the write at address 100
      start_run(s);
      run_beats(103, s + 2, 1'b0, 1'b0, 24'hFFFFFF, 0, k);
      abort_now();
      chk("abort100_busy",   64'(cap_busy), 0);
      chk("abort100_done",   64'(cap_done), 0);
      chk("abort100_wr_cnt", 64'(cap_wr_cnt), 101);
      rf_cap_start_pulse = 1'b1;
      rf_cap_abort_pulse = 1'b1;
      tick();
      rf_cap_start_pulse = 1'b0;
      rf_cap_abort_pulse = 1'b0;
      chk("start_abort_idle", 64'(cap_busy), 0);
      start_run(s);
      chk("restart_cnt0", 64'(cap_wr_cnt), 0);
      run_beats(6, s + 2, 1'b0, 1'b0, 24'hFFFFFF, 0, k);
      abort_now();
      chk("restart_wr_cnt", 64'(cap_wr_cnt), 4);

      // MDIO taking the memories mid-capture aborts the run
      start_run(s);
      run_beats(10, s + 2, 1'b0, 1'b0, 24'hFFFFFF, 0, k);
      mdio_read_en = 1'b1;
      adc_vld      = 1'b1;
      tick();
      mdio_read_en = 1'b0;
      adc_vld      = 1'b0;
      chk("mdio_abort_busy",   64'(cap_busy), 0);
      chk("mdio_abort_done",   64'(cap_done), 0);
      chk("mdio_abort_wr_cnt", 64'(cap_wr_cnt), 8);

      // Reset mid-capture clears every output
      start_run(s);
      run_beats(10, s + 2, 1'b0, 1'b0, 24'hFFFFFF, 0, k);
      rst     = 1'b1;
      adc_vld = 1'b1;
      tick();
      adc_vld = 1'b0;
      chk("midrst_chip_en", 64'(mem_chip_en), 0);
      chk("midrst_wr_en",   64'(mem_wr_en), 0);
      chk("midrst_addr",    64'(mem_addr), 0);
      chk("midrst_wdata",   64'(|mem_wdata), 0);
      chk("midrst_busy",    64'(cap_busy), 0);
      chk("midrst_wr_cnt",  64'(cap_wr_cnt), 0);
      rst = 1'b0;
      repeat (3) tick();

      chk("scoreboard_drained", 64'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gen_write_logic_capture.md
Name: gen_write_logic_capture

Overview:
Capture-side writer for the 24 packet-capture memories (36-bit x 32768) that the MDIO read path later drains.
- Samples 96 (or 48) 9-bit ADC paths on each valid beat.
- Packs paths 4i..4i+3 into the 36-bit word of memory i and writes all enabled memories at a shared, incrementing address.
- Runs from a register-file start pulse, with optional external trigger and trigger-to-capture delay.
- Sits between the ADC datapath and the memory macros. It owns the memory ports whenever mdio_read_en is low.

Parameters:
NUM_MEM, 24, number of capture memories
PATH_W, 9, bits per ADC path sample
ADDR_W, 15, memory address width; depth = 2^ADDR_W
DLY_W, 16, trigger-delay counter width

Ports:
clk  input  1  capture clock
rst  input  1  reset, synchronous, active-high
rf_96path_en  input  1  1: memories 0..23 written; 0: memories 0..11 only
rf_cap_start_pulse  input  1  one-cycle start request
rf_cap_abort_pulse  input  1  one-cycle abort request
rf_trig_mode  input  1  0: immediate; 1: wait for ext_trig
rf_trig_delay  input  DLY_W  valid beats skipped after trigger
ext_trig  input  1  external trigger level, rising edge used
mdio_read_en  input  1  MDIO read owns memories; blocks capture
adc_vld  input  1  sample beat valid
adc_din  input  NUM_MEM*4*PATH_W  path p at bits [p*9+:9]
mem_chip_en  output  NUM_MEM  per-memory chip enable
mem_wr_en  output  1  write strobe, shared
mem_addr  output  ADDR_W  shared write address
mem_wdata  output  NUM_MEM*36  memory i word at [i*36+:36]
cap_busy  output  1  state is ARM, DELAY or CAPTURE
cap_done  output  1  full buffer written
cap_wr_cnt  output  ADDR_W+1  words written this run

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. All outputs are 0, and the trigger edge register is cleared.
- States:
  - IDLE: on start with mdio_read_en=0, go to ARM. Clear cap_done, cap_wr_cnt, address and delay counter. A start while mdio_read_en=1 is ignored.
  - ARM:
    - rf_trig_mode=0: go to DELAY next cycle.
    - rf_trig_mode=1: wait for an ext_trig rising edge, detected with a one-flop history that is updated every cycle, including in IDLE.
  - DELAY: count adc_vld beats up to rf_trig_delay, then go to CAPTURE. With delay 0 the next cycle is CAPTURE, so no beat is skipped.
  - CAPTURE: each adc_vld beat issues one write.
    - After the write at address 2^ADDR_W-1 the state goes to DONE. cap_done rises in the same cycle as the write is presented.
    - The address never wraps.
  - DONE: cap_done held at 1, busy=0. Start re-arms as from IDLE.
- Write timing: outputs registered, so there is 1-cycle latency from the adc_vld edge to the memory strobe.
  - mem_wr_en=1 and mem_chip_en[i]=1 for enabled memories; mem_addr = current count.
  - mem_wdata[i*36+:36] = {path4i+3, path4i+2, path4i+1, path4i}.
  - Non-write cycles: wr_en=0, chip_en=0, addr and wdata hold their last value.
- 48-path mode: chip_en[23:12]=0 always. Address count and depth are unchanged.
- mode bit: rf_96path_en is sampled at ARM entry and held for the run.
- Abort: in any busy state, return to IDLE next cycle. No write occurs in that cycle, cap_done stays 0, cap_wr_cnt holds.
  - Abort and start in the same cycle: abort wins.
- mdio_read_en rising while busy: treated as abort.
- cap_wr_cnt increments on each issued write. It reaches 2^ADDR_W at done.
- A start while busy is ignored.
- adc_vld gaps stall the address; there is no timeout.

Decomposition:
- Shared package capture_pkg:
  - state encoding (IDLE=0, ARM=1, DELAY=2, CAPTURE=3, DONE=4)
  - NUM_MEM, PATH_W, ADDR_W, WORD_W=36
  - LAST_ADDR = 2^ADDR_W-1
  - MEM_48PATH = 12
- One sub-module, cap_word_pack: combinational mapping of adc_din into NUM_MEM 36-bit words. It is instanced once and its output is registered in the parent.

Test Plan:
1. 96-path immediate, delay 0, adc_vld constant 1, path p = p sample value:
   - first write one cycle after CAPTURE entry, addr 0, chip_en=24'hFFFFFF.
   - mem_wdata word 1 = {9'd7,9'd6,9'd5,9'd4}.
   - cap_done after 32768 writes, cap_wr_cnt=32768.
2. 48-path mode: chip_en=24'h000FFF on every write, bits 23:12 never set, and the done timing matches scenario 1.
3. rf_trig_mode=1, rf_trig_delay=5, ext_trig rises at cycle 100, adc_vld=1:
   - beats 0..4 after the edge are not written.
   - the first write uses the 6th beat at addr 0.
   - ext_trig held high without an edge leaves the block in ARM.
4. adc_vld toggled 1/0: the address advances only on valid beats, and wr_en pulses align 1 cycle after each valid beat.
5. Abort at addr 100:
   - IDLE next cycle, cap_wr_cnt=101 (or the value written), done=0.
   - a simultaneous start+abort stays IDLE.
   - a later start restarts at addr 0.
6. mdio_read_en=1 with a start pulse: no state change.
   - mdio_read_en asserted mid-capture aborts it.
   - rst asserted mid-capture zeroes all outputs on the next edge.
